// File: rtl/shift_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe_if
// Brief    : Control, data and status bundle for the shift_pipe register chain.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_pipe_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
);
  localparam int c_fill_w = $clog2(DEPTH + 1);

  logic                     en;
  logic                     clear;
  logic [1:0]               mode;
  logic [WIDTH-1:0]         din;
  logic [DEPTH*WIDTH-1:0]   load_data;
  logic [WIDTH-1:0]         dout;
  logic [DEPTH*WIDTH-1:0]   taps;
  logic [c_fill_w-1:0]      fill;
  logic                     valid;

  modport master (
    output en, clear, mode, din, load_data,
    input  dout, taps, fill, valid
  );

  modport slave (
    input  en, clear, mode, din, load_data,
    output dout, taps, fill, valid
  );
endinterface
`default_nettype wire

// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe
// Brief    : DEPTH-stage, WIDTH-bit shift register with rotate, parallel load,
//            hold and a saturating fill counter that flags a full window.
// Revision : 1.0 - initial release
// ============================================================================
module shift_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  shift_pipe_if.slave bus
);

  localparam int                  c_fill_w      = $clog2(DEPTH + 1);
  localparam logic [1:0]          c_mode_shift  = 2'b00;
  localparam logic [1:0]          c_mode_rotate = 2'b01;
  localparam logic [1:0]          c_mode_load   = 2'b10;
  localparam logic [c_fill_w-1:0] c_fill_full   = c_fill_w'(DEPTH);
  localparam logic [c_fill_w-1:0] c_fill_one    = c_fill_w'(1);

  logic [WIDTH-1:0]    r_stage     [DEPTH];
  logic [WIDTH-1:0]    w_stage_nxt [DEPTH];
  logic [c_fill_w-1:0] r_fill;
  logic [c_fill_w-1:0] w_fill_nxt;

  // Every stage is computed from pre-edge values so a shift moves data
  // exactly one stage per edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_stage_nxt[i] = r_stage[i];
    end
    w_fill_nxt = r_fill;

    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_stage_nxt[i] = '0;
      end
      w_fill_nxt = '0;
    end else if (bus.en) begin
      case (bus.mode)
        c_mode_shift: begin
          w_stage_nxt[0] = bus.din;
          for (int i = 1; i < DEPTH; i++) begin
            w_stage_nxt[i] = r_stage[i-1];
          end
          if (r_fill != c_fill_full) begin
            w_fill_nxt = r_fill + c_fill_one;
          end
        end
        c_mode_rotate: begin
          w_stage_nxt[0] = r_stage[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) begin
            w_stage_nxt[i] = r_stage[i-1];
          end
        end
        c_mode_load: begin
          for (int i = 0; i < DEPTH; i++) begin
            w_stage_nxt[i] = bus.load_data[i*WIDTH +: WIDTH];
          end
          w_fill_nxt = c_fill_full;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_fill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= w_stage_nxt[i];
      end
      r_fill <= w_fill_nxt;
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
      assign bus.taps[g*WIDTH +: WIDTH] = r_stage[g];
    end
  endgenerate

  assign bus.dout  = r_stage[DEPTH-1];
  assign bus.fill  = r_fill;
  assign bus.valid = (r_fill == c_fill_full);

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_pipe
// Brief    : Directed and random stimulus for two shift_pipe configurations
//            against a queue-based reference of the register window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  shift_pipe_if #(.WIDTH(1), .DEPTH(3)) bus_a ();
  shift_pipe_if #(.WIDTH(8), .DEPTH(4)) bus_b ();

  shift_pipe #(.WIDTH(1), .DEPTH(3)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  shift_pipe #(.WIDTH(8), .DEPTH(4)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  // Reference window: element i is stage i, newest sample at the front.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         fa = 0;
  int         fb = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int w, input bit r, input bit c, input bit e,
                      input logic [1:0] md, input logic [7:0] d, input logic [31:0] ld);
    logic [7:0]  q[$];
    logic [7:0]  mask;
    logic [7:0]  tmp;
    logic [31:0] et;
    int          f;
    int          dep;
    int          wid;
    @(negedge clk);
    if (w == 0) begin
      rst_a = r; bus_a.clear = c; bus_a.en = e; bus_a.mode = md;
      bus_a.din = d[0:0]; bus_a.load_data = ld[2:0];
      q = qa; f = fa; dep = 3; wid = 1;
    end else begin
      rst_b = r; bus_b.clear = c; bus_b.en = e; bus_b.mode = md;
      bus_b.din = d; bus_b.load_data = ld;
      q = qb; f = fb; dep = 4; wid = 8;
    end
    mask = 8'((1 << wid) - 1);
    @(posedge clk);
    if (r || c) begin
      q.delete();
      repeat (dep) q.push_back(8'h00);
      f = 0;
    end else if (e) begin
      case (md)
        2'b00: begin
          q.push_front(d & mask);
          void'(q.pop_back());
          if (f < dep) f++;
        end
        2'b01: begin
          tmp = q.pop_back();
          q.push_front(tmp);
        end
        2'b10: begin
          q.delete();
          for (int i = 0; i < dep; i++) q.push_back(8'(ld >> (i * wid)) & mask);
          f = dep;
        end
        default: ;
      endcase
    end
    #1;
    et = '0;
    for (int i = 0; i < dep; i++) et = et | (32'(q[i]) << (i * wid));
    if (w == 0) begin
      qa = q; fa = f;
      check("a_taps",  32'(bus_a.taps),  et);
      check("a_dout",  32'(bus_a.dout),  32'(q[dep-1]));
      check("a_fill",  32'(bus_a.fill),  32'(f));
      check("a_valid", 32'(bus_a.valid), 32'(f == dep));
      rst_a = 1'b0; bus_a.clear = 1'b0; bus_a.en = 1'b0;
    end else begin
      qb = q; fb = f;
      check("b_taps",  bus_b.taps,       et);
      check("b_dout",  32'(bus_b.dout),  32'(q[dep-1]));
      check("b_fill",  32'(bus_b.fill),  32'(f));
      check("b_valid", 32'(bus_b.valid), 32'(f == dep));
      rst_b = 1'b0; bus_b.clear = 1'b0; bus_b.en = 1'b0;
    end
  endtask

  initial begin
    rst_a = 1'b1; bus_a.clear = 1'b0; bus_a.en = 1'b0; bus_a.mode = 2'b00;
    bus_a.din = '0; bus_a.load_data = '0;
    rst_b = 1'b1; bus_b.clear = 1'b0; bus_b.en = 1'b0; bus_b.mode = 2'b00;
    bus_b.din = '0; bus_b.load_data = '0;
    repeat (3) qa.push_back(8'h00);
    repeat (4) qb.push_back(8'h00);

    // Reset held while shifting ones
    step(0, 1, 0, 1, 2'b00, 8'h01, 32'h0);
    step(0, 1, 0, 1, 2'b00, 8'h01, 32'h0);
    check("a_reset_taps", 32'(bus_a.taps), 32'h0);

    // Serial shift 1,0,1,1
    step(0, 0, 0, 1, 2'b00, 8'h01, 32'h0);
    step(0, 0, 0, 1, 2'b00, 8'h00, 32'h0);
    step(0, 0, 0, 1, 2'b00, 8'h01, 32'h0);
    check("a_valid_after_3", 32'(bus_a.valid), 32'h1);
    step(0, 0, 0, 1, 2'b00, 8'h01, 32'h0);
    check("a_shift_taps", 32'(bus_a.taps), 32'b011);
    check("a_fill_sat",   32'(bus_a.fill), 32'd3);

    // Load then rotate back to start
    step(0, 0, 0, 1, 2'b10, 8'h00, 32'b001);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2'b01, 8'h01, 32'h0);
    check("a_rotate_home", 32'(bus_a.taps), 32'b001);

    // Hold via en=0 and via mode 11
    step(0, 0, 0, 1, 2'b10, 8'h00, 32'b101);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2'b00, 8'h00, 32'h0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 2'b11, 8'h00, 32'h0);
    check("a_hold_taps", 32'(bus_a.taps), 32'b101);

    // Clear with en low, restart, reset during load, clear beats load
    step(0, 0, 1, 0, 2'b00, 8'h00, 32'h0);
    step(0, 0, 0, 1, 2'b00, 8'h01, 32'h0);
    check("a_restart_fill", 32'(bus_a.fill), 32'd1);
    step(0, 1, 0, 1, 2'b10, 8'h00, 32'b111);
    step(0, 0, 1, 1, 2'b10, 8'h00, 32'b111);
    check("a_clear_vs_load", 32'(bus_a.taps), 32'h0);

    // Wide configuration
    step(1, 1, 0, 0, 2'b00, 8'h00, 32'h0);
    step(1, 0, 0, 1, 2'b00, 8'h11, 32'h0);
    step(1, 0, 0, 1, 2'b00, 8'h22, 32'h0);
    step(1, 0, 0, 1, 2'b00, 8'h33, 32'h0);
    step(1, 0, 0, 1, 2'b00, 8'h44, 32'h0);
    check("b_window", bus_b.taps,       32'h11223344);
    check("b_dout",   32'(bus_b.dout),  32'h11);
    step(1, 0, 0, 1, 2'b00, 8'h55, 32'h0);
    check("b_window2", bus_b.taps,      32'h22334455);
    check("b_dout2",   32'(bus_b.dout), 32'h22);

    // Random traffic on both configurations
    for (int n = 0; n < 150; n++) begin
      step(n % 2,
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           8'($urandom),
           $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
